// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic port_id_t;

    localparam port_id_t PORT_CORE = 1'b0;
    localparam port_id_t PORT_HOST = 1'b1;

    localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port
// that did not win last time.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_t   last_grant,
    output logic       valid,
    output port_id_t   winner
);

    always_comb begin
        valid = |req;
        if (&req)
            winner = ~last_grant;
        else if (req[PORT_HOST])
            winner = PORT_HOST;
        else
            winner = PORT_CORE;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency data memory between the core
// and host ports. Define DMEM_ARB_STATS_EN to build the per-port grant counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int CTRL_W      = 3,
    parameter int MEM_LATENCY = 1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [CTRL_W-1:0] c_ctrl,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_stall,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [CTRL_W-1:0] h_ctrl,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_ack,
    output logic [DATA_W-1:0] h_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner,
    output logic [15:0]       stat_c,
    output logic [15:0]       stat_h
);

    localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(MEM_LATENCY - 1);

    state_t                 state;
    port_id_t               last_grant;
    port_id_t               owner_q;
    logic                   we_q;
    logic [LAT_CNT_W-1:0]   lat_cnt;
    logic                   pick_valid;
    port_id_t               pick_winner;

    rr_pick2 u_pick (
        .req        ({h_req, c_req}),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner_q    <= PORT_CORE;
            last_grant <= PORT_HOST;
            we_q       <= 1'b0;
            lat_cnt    <= '0;
            mem_ctrl   <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            c_rdata    <= '0;
            h_rdata    <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner_q <= pick_winner;
                        lat_cnt <= LAT_INIT;
                        state   <= BUSY;
                        if (pick_winner == PORT_HOST) begin
                            we_q      <= h_we;
                            mem_ctrl  <= h_ctrl;
                            mem_addr  <= h_addr;
                            mem_wdata <= h_wdata;
                        end else begin
                            we_q      <= c_we;
                            mem_ctrl  <= c_ctrl;
                            mem_addr  <= c_addr;
                            mem_wdata <= c_wdata;
                        end
                    end
                end
                BUSY: begin
                    if (lat_cnt == '0) begin
                        if (owner_q == PORT_HOST)
                            h_rdata <= we_q ? '0 : mem_rdata;
                        else
                            c_rdata <= we_q ? '0 : mem_rdata;
                        state <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP: begin
                    last_grant <= owner_q;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: strobes decode the state register directly, so reset drops mem_en without waiting for an edge.
    assign mem_en  = (state == BUSY);
    assign mem_we  = mem_en & we_q;
    assign c_ack   = (state == RESP) && (owner_q == PORT_CORE);
    assign h_ack   = (state == RESP) && (owner_q == PORT_HOST);
    assign c_stall = c_req & ~c_ack;
    assign owner   = owner_q;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_c_q;
    logic [15:0] stat_h_q;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            stat_c_q <= '0;
            stat_h_q <= '0;
        end else if (state == IDLE && pick_valid) begin
            if (pick_winner == PORT_HOST) begin
                if (stat_h_q != 16'hFFFF) stat_h_q <= stat_h_q + 16'd1;
            end else begin
                if (stat_c_q != 16'hFFFF) stat_c_q <= stat_c_q + 16'd1;
            end
        end
    end

    assign stat_c = stat_c_q;
    assign stat_h = stat_h_q;
`else
    assign stat_c = '0;
    assign stat_h = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance at MEM_LATENCY=1, one at 3.
module tb_dmem_arbiter;

    logic CLK = 1'b0;
    logic reset;
    always #5 CLK = ~CLK;

    // Instance 1: MEM_LATENCY = 1
    logic        c_req1, c_we1, h_req1, h_we1;
    logic [2:0]  c_ctrl1, h_ctrl1;
    logic [31:0] c_addr1, c_wdata1, h_addr1, h_wdata1, mem_rdata1;
    logic        c_ack1, c_stall1, h_ack1, mem_en1, mem_we1, owner1;
    logic [31:0] c_rdata1, h_rdata1, mem_addr1, mem_wdata1;
    logic [2:0]  mem_ctrl1;
    logic [15:0] stat_c1, stat_h1;

    // Instance 3: MEM_LATENCY = 3
    logic        c_req3, c_we3, h_req3, h_we3;
    logic [2:0]  c_ctrl3, h_ctrl3;
    logic [31:0] c_addr3, c_wdata3, h_addr3, h_wdata3, mem_rdata3;
    logic        c_ack3, c_stall3, h_ack3, mem_en3, mem_we3, owner3;
    logic [31:0] c_rdata3, h_rdata3, mem_addr3, mem_wdata3;
    logic [2:0]  mem_ctrl3;
    logic [15:0] stat_c3, stat_h3;

    dmem_arbiter #(.MEM_LATENCY(1)) dut1 (
        .CLK(CLK), .reset(reset),
        .c_req(c_req1), .c_we(c_we1), .c_ctrl(c_ctrl1), .c_addr(c_addr1), .c_wdata(c_wdata1),
        .c_ack(c_ack1), .c_rdata(c_rdata1), .c_stall(c_stall1),
        .h_req(h_req1), .h_we(h_we1), .h_ctrl(h_ctrl1), .h_addr(h_addr1), .h_wdata(h_wdata1),
        .h_ack(h_ack1), .h_rdata(h_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_ctrl(mem_ctrl1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
        .owner(owner1), .stat_c(stat_c1), .stat_h(stat_h1)
    );

    dmem_arbiter #(.MEM_LATENCY(3)) dut3 (
        .CLK(CLK), .reset(reset),
        .c_req(c_req3), .c_we(c_we3), .c_ctrl(c_ctrl3), .c_addr(c_addr3), .c_wdata(c_wdata3),
        .c_ack(c_ack3), .c_rdata(c_rdata3), .c_stall(c_stall3),
        .h_req(h_req3), .h_we(h_we3), .h_ctrl(h_ctrl3), .h_addr(h_addr3), .h_wdata(h_wdata3),
        .h_ack(h_ack3), .h_rdata(h_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_ctrl(mem_ctrl3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
        .owner(owner3), .stat_c(stat_c3), .stat_h(stat_h3)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
    endtask

    // One single-requester transaction on dut1, waiting a bounded time for the ack.
    task automatic txn1(input logic host, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rd);
        logic seen;
        seen = 1'b0;
        mem_rdata1 = rd;
        if (host) begin
            h_req1 = 1'b1; h_we1 = we; h_addr1 = addr; h_wdata1 = wdata;
        end else begin
            c_req1 = 1'b1; c_we1 = we; c_addr1 = addr; c_wdata1 = wdata;
        end
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            seen = host ? h_ack1 : c_ack1;
        end
        check("txn_ack_seen", seen, 1);
        if (host) check("txn_h_rdata", h_rdata1, we ? 32'h0 : rd);
        else      check("txn_c_rdata", c_rdata1, we ? 32'h0 : rd);
        c_req1 = 1'b0;
        h_req1 = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        {c_req1, c_we1, h_req1, h_we1} = '0;
        {c_ctrl1, h_ctrl1} = '0;
        {c_addr1, c_wdata1, h_addr1, h_wdata1, mem_rdata1} = '0;
        {c_req3, c_we3, h_req3, h_we3} = '0;
        {c_ctrl3, h_ctrl3} = '0;
        {c_addr3, c_wdata3, h_addr3, h_wdata3, mem_rdata3} = '0;

        // Reset values
        tick();
        tick();
        check("rst_mem_en",   mem_en1, 0);
        check("rst_acks",     {c_ack1, h_ack1, c_ack3, h_ack3}, 0);
        check("rst_owner",    owner1, 0);
        check("rst_mem_addr", mem_addr1, 0);
        check("rst_rdata",    {c_rdata1, h_rdata1}, 0);
        check("rst_stats",    {stat_c1, stat_h1}, 0);
        reset = 1'b0;
        tick();

        // Core load at latency 1
        c_req1 = 1'b1; c_we1 = 1'b0; c_addr1 = 32'h10; mem_rdata1 = 32'hDEADBEEF;
        #1;
        check("ld_c0_stall",  c_stall1, 1);
        check("ld_c0_mem_en", mem_en1, 0);
        tick();
        check("ld_c1_mem_en", mem_en1, 1);
        check("ld_c1_mem_we", mem_we1, 0);
        check("ld_c1_addr",   mem_addr1, 32'h10);
        check("ld_c1_stall",  c_stall1, 1);
        check("ld_c1_ack",    c_ack1, 0);
        tick();
        check("ld_c2_ack",    c_ack1, 1);
        check("ld_c2_rdata",  c_rdata1, 32'hDEADBEEF);
        check("ld_c2_stall",  c_stall1, 0);
        check("ld_c2_mem_en", mem_en1, 0);
        check("ld_c2_h_ack",  h_ack1, 0);
        c_req1 = 1'b0;
        tick();
        check("ld_c3_ack",    c_ack1, 0);

        // Simultaneous held requests after reset alternate core, host, core, host
        pulse_reset();
        c_req1 = 1'b1; h_req1 = 1'b1; mem_rdata1 = 32'h11112222;
        for (int k = 0; k < 4; k++) begin
            check("rr_idle_acks", {c_ack1, h_ack1}, 0);
            tick();
            check("rr_owner",  owner1, (k % 2));
            check("rr_mem_en", mem_en1, 1);
            tick();
            check("rr_c_ack",  c_ack1, (k % 2) == 0);
            check("rr_h_ack",  h_ack1, (k % 2) == 1);
            tick();
        end
        c_req1 = 1'b0; h_req1 = 1'b0;
        check("rr_h_rdata", h_rdata1, 32'h11112222);

        // Host read at latency 3, then host store; core rdata untouched
        h_req3 = 1'b1; h_we3 = 1'b0; h_addr3 = 32'h24; mem_rdata3 = 32'hA5A5A5A5;
        for (int i = 1; i <= 4; i++) tick();
        check("hrd_ack",     h_ack3, 1);
        check("hrd_rdata",   h_rdata3, 32'hA5A5A5A5);
        check("hrd_c_rdata", c_rdata3, 0);
        h_req3 = 1'b0;
        tick();
        h_req3 = 1'b1; h_we3 = 1'b1; h_ctrl3 = 3'b010; h_addr3 = 32'h20; h_wdata3 = 32'h12345678;
        #1;
        check("hwr_c0_mem_en", mem_en3, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("hwr_mem_en", mem_en3, 1);
            check("hwr_mem_we", mem_we3, 1);
            check("hwr_addr",   mem_addr3, 32'h20);
            check("hwr_wdata",  mem_wdata3, 32'h12345678);
            check("hwr_ctrl",   mem_ctrl3, 3'b010);
            check("hwr_ack",    h_ack3, 0);
            if (i == 1) begin
                h_addr3 = 32'h99; h_wdata3 = 32'h0; h_we3 = 1'b0;
            end
        end
        tick();
        check("hwr_c4_ack",    h_ack3, 1);
        check("hwr_c4_mem_en", mem_en3, 0);
        check("hwr_c4_rdata",  h_rdata3, 0);
        check("hwr_c4_owner",  owner3, 1);
        h_req3 = 1'b0;
        tick();

        // Core address change during BUSY is ignored
        c_req3 = 1'b1; c_we3 = 1'b0; c_addr3 = 32'h10; mem_rdata3 = 32'h0BADF00D;
        tick();
        check("chg_addr1", mem_addr3, 32'h10);
        c_addr3 = 32'h44;
        tick();
        check("chg_addr2", mem_addr3, 32'h10);
        tick();
        check("chg_addr3", mem_addr3, 32'h10);
        tick();
        check("chg_ack",     c_ack3, 1);
        check("chg_rdata",   c_rdata3, 32'h0BADF00D);
        check("chg_h_rdata", h_rdata3, 0);
        c_req3 = 1'b0;
        tick();

        // Request dropped before its ack still completes
        c_req1 = 1'b1; c_we1 = 1'b1; c_addr1 = 32'h8; c_wdata1 = 32'hCAFE;
        tick();
        c_req1 = 1'b0;
        tick();
        check("drop_ack",   c_ack1, 1);
        check("drop_stall", c_stall1, 0);
        tick();

        // Reset in the second BUSY cycle
        c_req3 = 1'b1; c_we3 = 1'b0; c_addr3 = 32'h30; mem_rdata3 = 32'h55AA55AA;
        tick();
        tick();
        check("rmb_busy2_en", mem_en3, 1);
        reset = 1'b1;
        #1;
        check("rmb_en_async", mem_en3, 0);
        check("rmb_no_ack",   c_ack3, 0);
        reset = 1'b0;
        #1;
        check("rmb_idle_stall", c_stall3, 1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("rmb_regrant_en", mem_en3, 1);
            check("rmb_regrant_ack", c_ack3, 0);
        end
        check("rmb_addr", mem_addr3, 32'h30);
        tick();
        check("rmb_ack",   c_ack3, 1);
        check("rmb_rdata", c_rdata3, 32'h55AA55AA);
        c_req3 = 1'b0;
        tick();

        // Grant counters: 5 core, 3 host
        pulse_reset();
        txn1(1'b0, 1'b0, 32'h100, 32'h0, 32'h1);
        txn1(1'b1, 1'b1, 32'h104, 32'h77, 32'h2);
        txn1(1'b0, 1'b1, 32'h108, 32'h88, 32'h3);
        txn1(1'b0, 1'b0, 32'h10C, 32'h0, 32'h4);
        txn1(1'b1, 1'b0, 32'h110, 32'h0, 32'h5);
        txn1(1'b0, 1'b0, 32'h114, 32'h0, 32'h6);
        txn1(1'b1, 1'b0, 32'h118, 32'h0, 32'h7);
        txn1(1'b0, 1'b0, 32'h11C, 32'h0, 32'h8);
        tick();
`ifdef DMEM_ARB_STATS_EN
        check("stat_c", stat_c1, 16'd5);
        check("stat_h", stat_h1, 16'd3);
`else
        check("stat_c", stat_c1, 16'd0);
        check("stat_h", stat_h1, 16'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
